// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types: the sequencer state encoding and the halt opcode.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    STALL,
    FLUSH,
    HALT
  } fetchState_e;

  localparam logic [10:0] HALT_OP = 11'h7FF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances on each enabled edge and holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers PC and IF/ID enables through boot, run, stall, flush and halt.
// Branch redirect and its mux selects are combinational in the cycle brReq is seen.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            instrOp,
  input  logic                   brReq,
  input  logic                   brUncond,
  input  logic                   hazardStall,
  input  logic                   resume,
  output logic                   pcWrite,
  output logic                   BrTaken,
  output logic                   UncondBr,
  output logic                   ifIdWrite,
  output logic                   ifIdFlush,
  output logic                   fetchValid,
  output logic                   halted,
  output logic [31:0]            fetchCount,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  fetchState_e state, nextState;
  logic [1:0]  flushCnt, nextFlushCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      flushCnt   <= 2'd0;
      fetchCount <= 32'd0;
    end else begin
      state    <= nextState;
      flushCnt <= nextFlushCnt;
      if (fetchValid) begin
        fetchCount <= fetchCount + 32'd1;
      end
    end
  end

  always_comb begin
    nextState    = state;
    nextFlushCnt = flushCnt;
    pcWrite      = 1'b0;
    BrTaken      = 1'b0;
    UncondBr     = 1'b0;
    ifIdWrite    = 1'b0;
    ifIdFlush    = 1'b0;
    fetchValid   = 1'b0;
    halted       = 1'b0;

    case (state)
      BOOT: begin
        ifIdFlush = 1'b1;
        nextState = RUN;
      end
      RUN: begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        fetchValid = 1'b1;
        if (hazardStall) begin
          nextState = STALL;
        end else if (instrOp == HALT_OP) begin
          nextState = HALT;
        end
      end
      STALL: begin
        if (!hazardStall) begin
          nextState = RUN;
        end
      end
      FLUSH: begin
        pcWrite   = 1'b1;
        ifIdFlush = 1'b1;
        if (flushCnt <= 2'd1) begin
          nextState    = RUN;
          nextFlushCnt = 2'd0;
        end else begin
          nextFlushCnt = flushCnt - 2'd1;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (resume) begin
          nextState = RUN;
        end
      end
      default: nextState = BOOT;
    endcase

    // A taken branch overrides stall/halt decisions and (re)starts the flush window.
    if (brReq && (state inside {RUN, STALL, FLUSH})) begin
      BrTaken      = 1'b1;
      UncondBr     = brUncond;
      pcWrite      = 1'b1;
      ifIdFlush    = 1'b1;
      nextState    = FLUSH;
      nextFlushCnt = FLUSH_LOAD;
    end
  end

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) stallCounter (
    .clk   (clk),
    .reset (reset),
    .enable(state == STALL),
    .count (stallCount)
  );

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1: bubble cycles inserted after a taken branch; legal range 1..3.
REQ-002 SHALL have parameter STALL_CNT_W, default 16: width of the saturating stall counter.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port instrOp  input  11: instruction[31:21] currently presented by instruction memory.
REQ-006 SHALL have port brReq  input  1: branch resolved taken this cycle.
REQ-007 SHALL have port brUncond  input  1: resolved branch is unconditional; qualified by brReq.
REQ-008 SHALL have port hazardStall  input  1: load-use hazard from decode.
REQ-009 SHALL have port resume  input  1: single-cycle pulse that releases HALT.
REQ-010 SHALL have port pcWrite  output  1: PC register load enable.
REQ-011 SHALL have port BrTaken  output  1: select for the PC branch mux.
REQ-012 SHALL have port UncondBr  output  1: select for the branch-offset mux.
REQ-013 SHALL have port ifIdWrite  output  1: IF/ID pipeline register load enable.
REQ-014 SHALL have port ifIdFlush  output  1: IF/ID register clears to NOP.
REQ-015 SHALL have port fetchValid  output  1: the instruction fetched this cycle is architectural.
REQ-016 SHALL have port halted  output  1: the sequencer is in HALT.
REQ-017 SHALL have port fetchCount  output  32: count of valid fetches.
REQ-018 SHALL have port stallCount  output  STALL_CNT_W: count of hazard-stall cycles.

Function
REQ-019 SHALL implement states BOOT, RUN, STALL, FLUSH and HALT.
REQ-020 BOOT SHALL last exactly 1 cycle after reset deasserts, to cover the clocked instruction-memory read, and SHALL then enter RUN; in BOOT: pcWrite=0, ifIdFlush=1, fetchValid=0.
REQ-021 RUN outputs SHALL be pcWrite=1, ifIdWrite=1, fetchValid=1, ifIdFlush=0.
REQ-022 brReq in RUN or STALL SHALL, in the same cycle (combinational path):
  - drive BrTaken=1, UncondBr=brUncond, pcWrite=1, ifIdFlush=1;
  - then enter FLUSH.
REQ-023 BrTaken and UncondBr SHALL be 0 whenever brReq=0 or the state is BOOT or HALT.
REQ-024 FLUSH SHALL hold for FLUSH_CYCLES cycles using a down-counter: pcWrite=1, ifIdFlush=1, fetchValid=0; it SHALL then return to RUN.
REQ-025 brReq during FLUSH SHALL redirect again and reload the flush counter to FLUSH_CYCLES.
REQ-026 hazardStall in RUN with no brReq SHALL enter STALL; STALL outputs SHALL be pcWrite=0, ifIdWrite=0, fetchValid=0.
REQ-027 STALL SHALL return to RUN in the first cycle hazardStall=0.
REQ-028 brReq SHALL take priority over hazardStall when both are asserted.
REQ-029 instrOp==HALT_OP in RUN, with no brReq or hazardStall, SHALL enter HALT on the next edge; HALT outputs SHALL be pcWrite=0, ifIdWrite=0, fetchValid=0, halted=1.
REQ-030 resume in HALT SHALL return to RUN; resume in any other state SHALL be ignored.
REQ-031 fetchCount SHALL increment on each edge where fetchValid=1, wrapping modulo 2^32.
REQ-032 stallCount SHALL increment on each edge spent in STALL and SHALL saturate at all-ones.

Reset
REQ-033 While reset=0 the block SHALL hold: state BOOT, pcWrite=0, ifIdWrite=0, ifIdFlush=1, fetchValid=0, BrTaken=0, UncondBr=0, halted=0, both counters 0, flush counter 0.
REQ-034 Reset asserted mid-FLUSH, mid-STALL or in HALT SHALL abort immediately, asynchronously, to the REQ-033 values.

Structure
REQ-035 The state enum and HALT_OP (11'h7FF) SHALL live in shared package fetch_pkg.
REQ-036 The stall counter SHALL be a separate sub-module sat_counter, parameterized by width, with enable and asynchronous active-low reset.
REQ-037 The next-state logic and the combinational outputs SHALL be separate from the state and counter flops.

Verification
REQ-038 Release reset, no other stimulus -> cycle 1 BOOT (pcWrite=0); cycles 2-11 pcWrite=1, fetchValid=1; fetchCount=10 after cycle 11.
REQ-039 RUN, one-cycle brReq=1 with brUncond=1 -> that cycle BrTaken=1, UncondBr=1, ifIdFlush=1; next cycle FLUSH with fetchValid=0; RUN again after 1 cycle (FLUSH_CYCLES=1).
REQ-040 hazardStall=1 for 3 cycles -> pcWrite=0 for 3 cycles; stallCount=3; RUN on the 4th cycle.
REQ-041 hazardStall=1 and brReq=1 in the same cycle -> BrTaken=1, pcWrite=1, FLUSH entered; stallCount unchanged.
REQ-042 instrOp=11'h7FF -> halted=1 and pcWrite=0 held for 20 cycles; resume pulse -> RUN next cycle; fetchCount frozen during HALT.
REQ-043 With STALL_CNT_W=4, stall for 20 cycles -> stallCount=15; reset asserted mid-stall -> all outputs at REQ-033 values before the next clock edge.
